// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a sync FIFO. It tracks occupancy from its own writes and the consumer's
// read_n strobe, and grants bounded bursts so that a write never overflows the FIFO.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          read_n,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          write_n,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [CNT_W-1:0]              count,
  output logic                          full,
  output logic                          empty,
  output logic                          rd_err
);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    write_n_q, write_n_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    rd_err_q, rd_err_d;

  logic [DATA_WIDTH-1:0]   req_word [NUM_REQ];
  logic                    wr, rd, space;
  logic [NUM_REQ-1:0]      owner_oh, others;
  logic [IDX_W-1:0]        ptr_after_owner;
  logic [IDX_W-1:0]        pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First set bit of mask at or after start, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] sel;
    logic             found;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(start) + k) % NUM_REQ);
      if (!found && mask[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Occupancy tracking; space looks at the count the FIFO will hold next cycle.
  always_comb begin
    wr       = ~write_n_q;
    rd       = ~read_n & ((count_q != '0) | wr);
    count_d  = count_q + {{(CNT_W-1){1'b0}}, wr} - {{(CNT_W-1){1'b0}}, rd};
    space    = (count_d < CNT_W'(FIFO_DEPTH));
    rd_err_d = rd_err_q | (~read_n & (count_q == '0) & ~wr);
  end

  always_comb begin
    owner_oh        = NUM_REQ'(1) << owner_q;
    others          = req & ~owner_oh;
    ptr_after_owner = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_d     = '0;
    write_n_d   = 1'b1;
    wr_data_d   = wr_data_q;
    pick_idx    = '0;
    case (state_q)
      IDLE: begin
        if ((|req) && space) begin
          pick_idx    = rr_pick(req, rr_ptr_q);
          owner_d     = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          write_n_d   = 1'b0;
          wr_data_d   = req_word[pick_idx];
          burst_cnt_d = BURST_W'(1);
          state_d     = BURST;
        end
      end
      BURST: begin
        if (!space) begin
          // Full stall: keep owner and burst count, issue nothing.
          state_d = BURST;
        end else if (req[owner_q] && (burst_cnt_q < BURST_W'(MAX_BURST))) begin
          grant_d     = owner_oh;
          write_n_d   = 1'b0;
          wr_data_d   = req_word[owner_q];
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          rr_ptr_d = ptr_after_owner;
          if (|others) begin
            // Hand over without an idle cycle; the releasing owner is excluded.
            pick_idx    = rr_pick(others, ptr_after_owner);
            owner_d     = pick_idx;
            grant_d     = NUM_REQ'(1) << pick_idx;
            write_n_d   = 1'b0;
            wr_data_d   = req_word[pick_idx];
            burst_cnt_d = BURST_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      grant_q     <= '0;
      write_n_q   <= 1'b1;
      wr_data_q   <= '0;
      count_q     <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_q     <= grant_d;
      write_n_q   <= write_n_d;
      wr_data_q   <= wr_data_d;
      count_q     <= count_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign grant   = grant_q;
  assign write_n = write_n_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: producers present queued words and advance on grant; a monitor checks every write
// against per-requester expected queues and tracks occupancy with the documented add/subtract rule.
module tb_fifo_wr_arbiter;
  localparam int NR = 4, DW = 8, DEPTH = 16, MB = 4, CW = 5;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic              read_n = 1'b1;
  logic [NR-1:0]     grant;
  logic              write_n;
  logic [DW-1:0]     wr_data;
  logic [CW-1:0]     count;
  logic              full, empty, rd_err;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .read_n(read_n),
    .grant(grant), .write_n(write_n), .wr_data(wr_data), .count(count),
    .full(full), .empty(empty), .rd_err(rd_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Producer agents: word list per requester, index advances on each grant seen.
  logic [DW-1:0] prod_mem [NR][256];
  int            prod_len [NR];
  int            prod_k   [NR];

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < NR; i++) begin
      if (!reset_n) prod_k[i] <= 0;
      else if (grant[i]) prod_k[i] <= prod_k[i] + 1;
    end
  end

  always_comb begin
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      int idx;
      idx = prod_k[i] + (grant[i] ? 1 : 0);
      if (idx < prod_len[i]) begin
        req[i]               = 1'b1;
        req_data[i*DW +: DW] = prod_mem[i][idx];
      end
    end
  end

  logic [DW-1:0] exp_q [NR][$];
  int            exp_own_q[$];

  task automatic push_word(input int i, input logic [DW-1:0] d);
    if (prod_len[i] < 250) begin
      prod_mem[i][prod_len[i]] = d;
      prod_len[i] = prod_len[i] + 1;
      exp_q[i].push_back(d);
    end
  endtask

  function automatic bit all_consumed();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NR; i++) if (exp_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  // Monitor: occupancy model and write scoreboard.
  int model_cnt = 0;
  bit model_err = 0;
  int run_len = 0;
  int run_own = -1;

  always @(negedge clock) begin
    if (!reset_n) begin
      model_cnt = 0;
      model_err = 0;
      run_len   = 0;
      run_own   = -1;
    end else begin
      int own;
      int wr, rd;
      check(int'(count) == model_cnt, "count", int'(count), model_cnt);
      check(full == (model_cnt == DEPTH), "full", int'(full), int'(model_cnt == DEPTH));
      check(empty == (model_cnt == 0), "empty", int'(empty), int'(model_cnt == 0));
      check(rd_err == model_err, "rd_err", int'(rd_err), int'(model_err));
      check(((write_n == 1'b0) == (grant != '0)) && $onehot0(grant), "grant_vs_write_n",
            int'(grant), int'(!write_n));
      if (!write_n) begin
        own = 0;
        for (int i = NR - 1; i >= 0; i--) if (grant[i]) own = i;
        check(model_cnt < DEPTH, "no_overflow", model_cnt, DEPTH - 1);
        if (exp_q[own].size() == 0) begin
          check(1'b0, "unexpected_write", own, -1);
        end else begin
          logic [DW-1:0] d;
          d = exp_q[own].pop_front();
          check(wr_data == d, "wr_data", int'(wr_data), int'(d));
        end
        if (exp_own_q.size() > 0) begin
          int e;
          e = exp_own_q.pop_front();
          check(own == e, "owner", own, e);
        end
        if (own == run_own) run_len++;
        else begin
          run_own = own;
          run_len = 1;
        end
        check(run_len <= MB, "burst_len", run_len, MB);
      end else begin
        run_len = 0;
        run_own = -1;
      end
      wr = write_n ? 0 : 1;
      rd = (!read_n && (model_cnt != 0 || wr == 1)) ? 1 : 0;
      if (!read_n && model_cnt == 0 && wr == 0) model_err = 1;
      model_cnt = model_cnt + wr - rd;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, optionally checks async reset values.
  task automatic do_reset(input bit check_vals);
    #2;
    reset_n = 1'b0;
    read_n  = 1'b1;
    #1;
    if (check_vals) begin
      check(grant == '0, "rst_grant", int'(grant), 0);
      check(write_n == 1'b1, "rst_write_n", int'(write_n), 1);
      check(wr_data == '0, "rst_wr_data", int'(wr_data), 0);
      check(count == '0, "rst_count", int'(count), 0);
      check(full == 1'b0, "rst_full", int'(full), 0);
      check(empty == 1'b1, "rst_empty", int'(empty), 1);
      check(rd_err == 1'b0, "rst_rd_err", int'(rd_err), 0);
    end
    for (int i = 0; i < NR; i++) begin
      prod_len[i] = 0;
      exp_q[i].delete();
    end
    exp_own_q.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget, input int rd_pct);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      read_n = ($urandom_range(0, 99) < rd_pct) ? 1'b0 : 1'b1;
      step(1);
      if (all_consumed() && write_n) done = 1'b1;
    end
    read_n = 1'b1;
    check(done, "drain_timeout", int'(done), 1);
  endtask

  initial begin
    int pat2[9]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1};
    int pat6[7]  = '{1, 0, 0, 0, 0, 0, 1};
    bit reached;

    step(2);
    reset_n = 1'b1;
    step(1);

    // Single requester: 4-word burst, one idle cycle, then the last two words.
    do_reset(1'b1);
    for (int w = 0; w < 6; w++) begin
      push_word(0, 8'(8'h10 + w));
      exp_own_q.push_back(0);
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      check(int'(write_n) == pat2[c], "single_req_write_n", int'(write_n), pat2[c]);
    end
    check(count == 5'd6, "single_req_count", int'(count), 6);
    step(1);

    // Fairness: all four requesting, bursts of 4 in order until full.
    do_reset(1'b0);
    for (int i = 0; i < NR; i++) begin
      for (int w = 0; w < 5; w++) push_word(i, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < NR; i++) repeat (MB) exp_own_q.push_back(i);
    repeat (18) @(negedge clock);
    check(full == 1'b1, "fair_full", int'(full), 1);
    check(write_n == 1'b1, "fair_write_n", int'(write_n), 1);
    check(grant == '0, "fair_grant", int'(grant), 0);
    check(count == 5'd16, "fair_count", int'(count), 16);
    step(1);
    drain(200, 60);

    // Mid-burst drop: req1 runs dry after 2 words, req2 takes over with no gap.
    do_reset(1'b0);
    push_word(1, 8'hA1);
    push_word(1, 8'hA2);
    push_word(2, 8'hB1);
    push_word(2, 8'hB2);
    push_word(2, 8'hB3);
    exp_own_q.push_back(1);
    exp_own_q.push_back(1);
    repeat (3) exp_own_q.push_back(2);
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      check(int'(write_n) == pat6[c], "drop_write_n", int'(write_n), pat6[c]);
    end
    step(1);

    // Near full with a read every cycle: occupancy must never pass 16.
    do_reset(1'b0);
    for (int w = 0; w < 15; w++) push_word(0, 8'(w + 8'h40));
    reached = 1'b0;
    for (int c = 0; c < 80 && !reached; c++) begin
      @(negedge clock);
      if (count == 5'd15 && write_n) reached = 1'b1;
    end
    check(reached, "fill_to_15", int'(count), 15);
    step(1);
    read_n = 1'b0;
    for (int w = 0; w < 20; w++) push_word(0, 8'(w + 8'h80));
    step(40);
    read_n = 1'b1;
    drain(200, 50);

    // Empty read sets the sticky error.
    do_reset(1'b0);
    read_n = 1'b0;
    @(negedge clock);
    check(rd_err == 1'b0, "empty_read_pre", int'(rd_err), 0);
    step(1);
    read_n = 1'b1;
    @(negedge clock);
    check(rd_err == 1'b1, "empty_read_err", int'(rd_err), 1);
    check(count == '0, "empty_read_count", int'(count), 0);
    step(5);
    check(rd_err == 1'b1, "empty_read_sticky", int'(rd_err), 1);

    // Random traffic with a mid-cycle reset in the middle.
    do_reset(1'b0);
    for (int c = 0; c < 700; c++) begin
      int rd_pct;
      rd_pct = (c < 300) ? 20 : 55;
      if ($urandom_range(0, 99) < 45) push_word($urandom_range(0, NR - 1), 8'($urandom_range(0, 255)));
      read_n = ($urandom_range(0, 99) < rd_pct) ? 1'b0 : 1'b1;
      if (c == 350) do_reset(1'b1);
      else step(1);
    end
    drain(3000, 50);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
